// File: rtl/fifo_burst_reader.sv
// Read-side burst controller for the synchronous FIFO: pops burst_len words and
// streams them out through a 2-entry buffer on a valid/ready interface.
module fifo_burst_reader #(
   parameter int unsigned FIFO_WIDTH = 16,
   parameter int unsigned BURST_W    = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [BURST_W-1:0]    burst_len,
   output logic                  busy,
   output logic                  done,
   input  logic                  fifo_empty,
   input  logic                  fifo_underflow,
   input  logic [FIFO_WIDTH-1:0] fifo_data_out,
   output logic                  fifo_rd_en,
   output logic [FIFO_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [BURST_W-1:0]    rd_count,
   output logic                  err_underflow
);

   localparam int unsigned OCC_W = 2;

   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

   state_t                state, state_nxt;
   logic [BURST_W-1:0]    len_q, len_nxt;
   logic [BURST_W-1:0]    issued_q, issued_nxt;
   logic [BURST_W-1:0]    rd_count_nxt;
   logic                  inflight_q;
   logic [OCC_W-1:0]      occ_q, occ_nxt;
   logic [FIFO_WIDTH-1:0] buf1_q, buf1_nxt, m_data_nxt;
   logic                  err_nxt;
   logic                  push, pop, uf_cap;

   // Credit check counts the word in flight so the buffer can never overflow.
   always_comb begin
      fifo_rd_en = (state == READ) && !fifo_empty && (issued_q < len_q) &&
                   ((3'(occ_q) + 3'(inflight_q)) < 3'd2);
   end

   // Output buffer: m_data is the head entry, buf1_q the second.
   always_comb begin
      pop        = m_valid && m_ready;
      push       = inflight_q && !fifo_underflow;
      occ_nxt    = occ_q;
      m_data_nxt = m_data;
      buf1_nxt   = buf1_q;
      case ({push, pop})
         2'b10: begin
            if (occ_q == OCC_W'(0)) m_data_nxt = fifo_data_out;
            else                    buf1_nxt   = fifo_data_out;
            occ_nxt = occ_q + OCC_W'(1);
         end
         2'b01: begin
            if (occ_q == OCC_W'(2)) m_data_nxt = buf1_q;
            occ_nxt = occ_q - OCC_W'(1);
         end
         2'b11: begin
            if (occ_q == OCC_W'(1)) begin
               m_data_nxt = fifo_data_out;
            end else begin
               m_data_nxt = buf1_q;
               buf1_nxt   = fifo_data_out;
            end
         end
         default: ;
      endcase
   end

   // Next-state and counter logic.
   always_comb begin
      state_nxt    = state;
      len_nxt      = len_q;
      issued_nxt   = issued_q;
      rd_count_nxt = rd_count;
      err_nxt      = err_underflow;
      uf_cap       = inflight_q && fifo_underflow;

      if (pop && (rd_count != len_q)) rd_count_nxt = rd_count + BURST_W'(1);
      if (fifo_rd_en) issued_nxt = issued_nxt + BURST_W'(1);
      // A failed read is forgotten so the same word gets requested again.
      if (uf_cap) begin
         err_nxt    = 1'b1;
         issued_nxt = issued_nxt - BURST_W'(1);
      end

      case (state)
         IDLE: begin
            if (start) begin
               if (burst_len != BURST_W'(0)) begin
                  state_nxt    = READ;
                  len_nxt      = burst_len;
                  issued_nxt   = '0;
                  rd_count_nxt = '0;
                  err_nxt      = 1'b0;
               end else begin
                  state_nxt = DONE;
               end
            end
         end
         READ: begin
            if (issued_nxt == len_q) state_nxt = DRAIN;
         end
         DRAIN: begin
            if (uf_cap)                                       state_nxt = READ;
            else if (!inflight_q && (occ_q == OCC_W'(0)))    state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         len_q         <= '0;
         issued_q      <= '0;
         inflight_q    <= 1'b0;
         occ_q         <= '0;
         buf1_q        <= '0;
         m_data        <= '0;
         m_valid       <= 1'b0;
         rd_count      <= '0;
         err_underflow <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
      end else begin
         state         <= state_nxt;
         len_q         <= len_nxt;
         issued_q      <= issued_nxt;
         inflight_q    <= fifo_rd_en;
         occ_q         <= occ_nxt;
         buf1_q        <= buf1_nxt;
         m_data        <= m_data_nxt;
         m_valid       <= (occ_nxt != OCC_W'(0));
         rd_count      <= rd_count_nxt;
         err_underflow <= err_nxt;
         busy          <= (state_nxt == READ) || (state_nxt == DRAIN);
         done          <= (state_nxt == DONE);
      end
   end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: a queue-based FIFO environment and a queue-based
// reference model compared against the DUT every cycle, plus directed scenarios.
module tb_fifo_burst_reader;

   localparam int unsigned FW = 16;
   localparam int unsigned BW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [BW-1:0] burst_len;
   logic          busy, done;
   logic          fifo_empty, fifo_underflow;
   logic [FW-1:0] fifo_data_out;
   logic          fifo_rd_en;
   logic [FW-1:0] m_data;
   logic          m_valid, m_ready;
   logic [BW-1:0] rd_count;
   logic          err_underflow;

   always #5 clk = ~clk;

   fifo_burst_reader #(.FIFO_WIDTH(FW), .BURST_W(BW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .burst_len(burst_len),
      .busy(busy), .done(done), .fifo_empty(fifo_empty),
      .fifo_underflow(fifo_underflow), .fifo_data_out(fifo_data_out),
      .fifo_rd_en(fifo_rd_en), .m_data(m_data), .m_valid(m_valid),
      .m_ready(m_ready), .rd_count(rd_count), .err_underflow(err_underflow)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // FIFO environment contents and pending underflow injection
   logic [FW-1:0] fq[$];
   bit            inject_uf;

   // Reference model: phase 0 idle, 1 reading, 2 draining, 3 done
   int            m_phase, m_len, m_issued, m_cnt;
   bit            m_infl, m_err;
   logic [FW-1:0] mq[$];

   // Observed statistics
   int            s_rd, s_xfer, s_done, max_out, cyc, start_cyc, first_v;
   bit            rd_when_empty;
   logic [FW-1:0] got[$];
   logic [FW-1:0] exp_w[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic void model_reset();
      m_phase = 0; m_len = 0; m_issued = 0; m_cnt = 0; m_infl = 0; m_err = 0;
      mq.delete();
   endfunction

   // Advance the model by one clock using the inputs present this cycle.
   function automatic void model_step(input bit rd);
      int iss, ph, occ_before;
      iss = m_issued; ph = m_phase; occ_before = mq.size();
      if (mq.size() != 0 && m_ready) begin
         void'(mq.pop_front());
         if (m_cnt < m_len) m_cnt++;
      end
      if (m_infl) begin
         if (fifo_underflow) begin m_err = 1; iss--; end
         else mq.push_back(fifo_data_out);
      end
      if (rd) iss++;
      case (m_phase)
         0: if (start) begin
               if (burst_len != 0) begin
                  ph = 1; m_len = int'(burst_len); iss = 0; m_cnt = 0; m_err = 0;
               end else ph = 3;
            end
         1: if (iss == m_len) ph = 2;
         2: if (m_infl && fifo_underflow) ph = 1;
            else if (!m_infl && occ_before == 0) ph = 3;
         default: ph = 0;
      endcase
      m_infl = rd; m_issued = iss; m_phase = ph;
   endfunction

   function automatic void clear_stats();
      s_rd = 0; s_xfer = 0; s_done = 0; max_out = 0; first_v = -1;
      rd_when_empty = 0; got.delete(); start_cyc = cyc;
   endfunction

   // One clock: compare at negedge, advance model, then let the FIFO respond.
   task automatic cycle();
      bit m_rd, rd_act;
      fifo_empty = (fq.size() == 0);
      @(negedge clk);
      m_rd = (m_phase == 1) && !fifo_empty && (m_issued < m_len) &&
             ((mq.size() + int'(m_infl)) < 2);
      check("fifo_rd_en", 32'(fifo_rd_en), 32'(m_rd));
      check("busy", 32'(busy), 32'(m_phase == 1 || m_phase == 2));
      check("done", 32'(done), 32'(m_phase == 3));
      check("m_valid", 32'(m_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) check("m_data", 32'(m_data), 32'(mq[0]));
      check("rd_count", 32'(rd_count), 32'(m_cnt));
      check("err_underflow", 32'(err_underflow), 32'(m_err));
      if (fifo_rd_en) begin
         s_rd++;
         if (fifo_empty) rd_when_empty = 1;
      end
      if (s_rd - s_xfer > max_out) max_out = s_rd - s_xfer;
      if (m_valid && first_v < 0) first_v = cyc;
      if (m_valid && m_ready) begin s_xfer++; got.push_back(m_data); end
      if (done) s_done++;
      model_step(m_rd);
      rd_act = fifo_rd_en;
      @(posedge clk); #1;
      fifo_underflow = 1'b0;
      if (rd_act) begin
         if (inject_uf) begin
            fifo_underflow = 1'b1; fifo_data_out = FW'(32'hDEAD); inject_uf = 0;
         end else if (fq.size() != 0) begin
            fifo_data_out = fq.pop_front();
         end
      end
      cyc++;
   endtask

   task automatic run_until_done(input string name, input int budget);
      int n = 0;
      while (s_done == 0 && n < budget) begin cycle(); n++; end
      cycle();
      check({name, "_done_pulses"}, 32'(s_done), 32'd1);
      check({name, "_busy_after"}, 32'(busy), 32'd0);
   endtask

   task automatic check_got(input string name);
      check({name, "_word_count"}, 32'(got.size()), 32'(exp_w.size()));
      for (int i = 0; i < exp_w.size() && i < got.size(); i++)
         check({name, "_word"}, 32'(got[i]), 32'(exp_w[i]));
   endtask

   task automatic pulse_start(input int len);
      start = 1'b1; burst_len = BW'(len);
      cycle();
      start = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst_n = 1'b0; start = 1'b0; burst_len = '0; m_ready = 1'b1;
      fifo_underflow = 1'b0; fifo_data_out = '0; fifo_empty = 1'b1;
      inject_uf = 0; cyc = 0;
      model_reset(); clear_stats();
      #12;
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_rd_en", 32'(fifo_rd_en), 32'd0);
      check("reset_m_valid", 32'(m_valid), 32'd0);
      check("reset_m_data", 32'(m_data), 32'd0);
      check("reset_rd_count", 32'(rd_count), 32'd0);
      check("reset_err", 32'(err_underflow), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Basic burst
      clear_stats();
      fq = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
      pulse_start(4);
      run_until_done("basic", 40);
      exp_w = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
      check_got("basic");
      check("basic_reads", 32'(s_rd), 32'd4);
      check("basic_rd_count", 32'(rd_count), 32'd4);
      check("basic_latency", 32'(first_v - start_cyc), 32'd3);

      // Backpressure
      clear_stats();
      for (int i = 0; i < 6; i++) fq.push_back(FW'(16'h0010 + i));
      pulse_start(6);
      n = 0;
      while (!m_valid && n < 10) begin cycle(); n++; end
      m_ready = 1'b0;
      repeat (5) begin
         cycle();
         check("bp_hold_data", 32'(m_data), 32'h0010);
         check("bp_hold_valid", 32'(m_valid), 32'd1);
      end
      check("bp_rd_stalled", 32'(fifo_rd_en), 32'd0);
      m_ready = 1'b1;
      run_until_done("bp", 60);
      exp_w.delete();
      for (int i = 0; i < 6; i++) exp_w.push_back(FW'(16'h0010 + i));
      check_got("bp");
      check("bp_max_outstanding", 32'(max_out <= 2), 32'd1);

      // Empty stall
      clear_stats();
      fq = '{16'h0021};
      pulse_start(3);
      repeat (10) cycle();
      check("stall_reads", 32'(s_rd), 32'd1);
      fq.push_back(16'h0022); fq.push_back(16'h0023);
      run_until_done("stall", 40);
      exp_w = '{16'h0021, 16'h0022, 16'h0023};
      check_got("stall");
      check("stall_rd_count", 32'(rd_count), 32'd3);
      check("stall_err", 32'(err_underflow), 32'd0);
      check("stall_rd_when_empty", 32'(rd_when_empty), 32'd0);

      // Underflow recovery
      clear_stats();
      fq = '{16'h0031, 16'h0032};
      inject_uf = 1;
      pulse_start(2);
      run_until_done("uf", 40);
      exp_w = '{16'h0031, 16'h0032};
      check_got("uf");
      check("uf_reads", 32'(s_rd), 32'd3);
      check("uf_err", 32'(err_underflow), 32'd1);

      // Zero length, then a start ignored while busy
      clear_stats();
      pulse_start(0);
      check("zero_done", 32'(done), 32'd1);
      check("zero_rd_en", 32'(fifo_rd_en), 32'd0);
      cycle();
      check("zero_done_once", 32'(done), 32'd0);
      check("zero_reads", 32'(s_rd), 32'd0);
      clear_stats();
      fq = '{16'h0041, 16'h0042, 16'h0043, 16'h0044, 16'h0045};
      pulse_start(3);
      cycle();
      pulse_start(5);
      run_until_done("ign", 40);
      exp_w = '{16'h0041, 16'h0042, 16'h0043};
      check_got("ign");
      check("ign_reads", 32'(s_rd), 32'd3);
      check("ign_fifo_left", 32'(fq.size()), 32'd2);

      // Reset with one word buffered and one in flight
      clear_stats();
      fq = '{16'h0061, 16'h0062, 16'h0063, 16'h0064};
      m_ready = 1'b0;
      pulse_start(4);
      n = 0;
      while (!(mq.size() == 1 && m_infl) && n < 10) begin cycle(); n++; end
      check("rst_reached_state", 32'(mq.size() == 1 && m_infl), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
      check("rst_m_valid", 32'(m_valid), 32'd0);
      check("rst_m_data", 32'(m_data), 32'd0);
      check("rst_rd_count", 32'(rd_count), 32'd0);
      check("rst_err", 32'(err_underflow), 32'd0);
      model_reset(); fq.delete(); fifo_underflow = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      clear_stats();
      m_ready = 1'b1;
      fq = '{16'h0051};
      pulse_start(1);
      run_until_done("post_rst", 20);
      exp_w = '{16'h0051};
      check_got("post_rst");
      check("post_rst_rd_count", 32'(rd_count), 32'd1);

      // Randomized traffic: random ready, FIFO fill, start pulses and underflows
      for (int i = 0; i < 2500; i++) begin
         m_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 9) < 4 && fq.size() < 20) fq.push_back(FW'($urandom));
         start = ($urandom_range(0, 7) == 0);
         burst_len = ($urandom_range(0, 9) == 0) ? BW'(0) : BW'($urandom_range(1, 12));
         if (!inject_uf && $urandom_range(0, 19) == 0) inject_uf = 1;
         cycle();
      end
      start = 1'b0; m_ready = 1'b1; inject_uf = 0;
      n = 0;
      while (m_phase != 0 && n < 500) begin
         if (fq.size() == 0) fq.push_back(FW'($urandom));
         cycle(); n++;
      end
      cycle();
      check("random_settled_busy", 32'(busy), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
